tt_checker: RTL and testbench
=============================

Name: tt_checker

Overview:
Hardware response checker for exhaustive truth-table tests of small combinational blocks in the basic-operators labs.
- A stimulus source sweeps input vectors 0..2**N_IN-1 in order and presents each vector with the DUT outputs it produced.
- tt_checker compares each sample against a parameterised expected table, counts mismatches and records the first failing vector.
- It reports pass/fail and done once the sweep is complete.

Parameters:
N_IN, 2, number of DUT inputs; the sweep has 2**N_IN vectors.
N_OUT, 2, number of DUT outputs compared per vector.
EXP_TABLE, 8'hB1, packed expected outputs; entry v sits at bits [v*N_OUT +: N_OUT]. The default encodes {buf_a,not_b} for inputs {a,b}: v0=01, v1=00, v2=11, v3=10.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse that clears results and begins a sweep.
in_valid  input  1  sample (in_vec, dut_out) is present.
in_ready  output  1  checker accepts a sample this cycle.
in_vec  input  N_IN  input vector applied to the DUT.
dut_out  input  N_OUT  DUT outputs for in_vec.
busy  output  1  sweep in progress.
done  output  1  sweep complete; held until next start or reset.
pass  output  1  valid while done; 1 when err_count==0 and no sequence error.
err_count  output  N_IN+1  number of mismatching samples; cannot overflow.
first_fail_valid  output  1  at least one mismatch recorded.
first_fail_idx  output  N_IN  in_vec of the first mismatching sample.
seq_err  output  1  sticky; a sample arrived with in_vec != expected index.

Behaviour:
- Reset (async, rst_n low) forces:
  - state IDLE;
  - in_ready, busy, done, pass, first_fail_valid, seq_err = 0;
  - err_count = 0, first_fail_idx = 0, expected index = 0.
- Reset asserted mid-sweep discards all progress.
- FSM states:
  - IDLE: in_ready=0. start moves to RUN next cycle, clearing all result registers and the index.
  - RUN: busy=1, in_ready=1. A handshake is in_valid & in_ready.
    - Each handshake compares dut_out against EXP_TABLE[in_vec].
    - Mismatch: err_count+1 on the next edge. If first_fail_valid==0, also capture first_fail_idx=in_vec and set first_fail_valid.
    - in_vec != expected index: set seq_err. The comparison still uses in_vec.
    - The expected index increments on every handshake.
    - A handshake while the index equals 2**N_IN-1 moves the FSM to DONE.
  - DONE: busy=0, in_ready=0, done=1, pass=(err_count==0 && !seq_err). Outputs hold; start re-enters RUN with results cleared.
- Latency: all result outputs update one cycle after the handshake. done and pass rise one cycle after the last handshake, in the same cycle the last err_count update becomes visible.
- start while in RUN aborts and restarts: results are cleared and the index returns to 0. A same-cycle handshake is dropped.
- in_valid in IDLE or DONE is ignored, with no state change.
- Index wrap: the index is N_IN bits wide and returns to 0 only through start or reset, never by overflow.
- All outputs are registered. No combinational path from inputs to outputs, except in_ready, which is decoded from state only.

Decomposition:
- Package tt_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the default EXP_TABLE constant for the buf/not lab.
- Sub-module tt_expect_lookup (combinational, N_IN/N_OUT/EXP_TABLE parameters) maps in_vec to expected outputs. tt_checker instantiates it once.

Test Plan:
1. Reset, start, then 4 in-order correct samples (00/01, 01/00, 10/11, 11/10) -> done=1 one cycle after the 4th handshake, pass=1, err_count=0, first_fail_valid=0, seq_err=0.
2. Same sweep with the v2 sample carrying dut_out=10 and the v3 sample carrying 00 -> err_count=2, first_fail_idx=2, first_fail_valid=1, pass=0.
3. Samples in order 0,2,1,3 with otherwise correct outputs -> seq_err=1, err_count=0, pass=0, done after 4 handshakes.
4. rst_n pulsed low after the 2nd handshake -> all outputs 0 immediately (asynchronous). A new start plus a clean sweep then gives pass=1.
5. start pulsed in RUN after 3 handshakes that include one mismatch -> err_count returns to 0, index 0. A full correct sweep then gives pass=1.
6. in_valid held high in IDLE and in DONE -> in_ready=0, err_count and done unchanged. A later start re-runs with results cleared.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table response checker.
package tt_pkg;

  // Checker FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tt_state_e;

  // Default lab geometry: two inputs {a,b}, two outputs {buf_a,not_b}.
  localparam int TT_N_IN  = 2;
  localparam int TT_N_OUT = 2;

  // Expected outputs for the buf/not lab, entry v at bits [v*2 +: 2]:
  // v0=01, v1=00, v2=11, v3=10.
  localparam logic [7:0] TT_EXP_TABLE_DEFAULT = 8'hB1;

endpackage

// File: rtl/tt_expect_lookup.sv
// Combinational lookup of the expected DUT outputs for one input vector.
module tt_expect_lookup
  import tt_pkg::*;
#(
  parameter int N_IN  = TT_N_IN,
  parameter int N_OUT = TT_N_OUT,
  parameter logic [(N_OUT<<N_IN)-1:0] EXP_TABLE = TT_EXP_TABLE_DEFAULT
) (
  input  logic [N_IN-1:0]  i_vec,
  output logic [N_OUT-1:0] o_exp
);

  // Slice the packed table at the entry selected by the input vector.
  always_comb begin
    o_exp = EXP_TABLE[int'(i_vec) * N_OUT +: N_OUT];
  end

endmodule

// File: rtl/tt_checker.sv
// Exhaustive truth-table response checker.
//
// Sample handshake: a sample (in_vec, dut_out) transfers on a rising clk edge
// when in_valid and in_ready are both high. in_ready is high exactly while the
// FSM is in RUN; a sample offered in the same cycle as start is dropped. The
// source may hold in_valid high at any time; outside RUN it is ignored.
module tt_checker
  import tt_pkg::*;
#(
  parameter int N_IN  = TT_N_IN,
  parameter int N_OUT = TT_N_OUT,
  parameter logic [(N_OUT<<N_IN)-1:0] EXP_TABLE = TT_EXP_TABLE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_vec,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic              first_fail_valid,
  output logic [N_IN-1:0]   first_fail_idx,
  output logic              seq_err,
  output logic [1:0]        dbg_state
);

  localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

  tt_state_e         r_state;
  tt_state_e         w_state_next;
  logic [N_IN-1:0]   r_idx;
  logic [N_IN:0]     r_err_count;
  logic              r_ffv;
  logic [N_IN-1:0]   r_ffi;
  logic              r_seq_err;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;

  logic [N_OUT-1:0]  w_exp;
  logic              w_hs;
  logic              w_mismatch;
  logic              w_seq_hit;
  logic [N_IN:0]     w_err_next;
  logic              w_seq_next;

  tt_expect_lookup #(
    .N_IN      (N_IN),
    .N_OUT     (N_OUT),
    .EXP_TABLE (EXP_TABLE)
  ) u_lookup (
    .i_vec (in_vec),
    .o_exp (w_exp)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: start always (re)enters RUN; the handshake on the last index ends the sweep.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (start) w_state_next = RUN;
      RUN: begin
        if (start) begin
          w_state_next = RUN;
        end else if (w_hs && (r_idx == LAST_IDX)) begin
          w_state_next = DONE;
        end
      end
      DONE: if (start) w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  // Output/decode: in_ready from state only, plus the per-sample compare terms.
  always_comb begin
    in_ready   = (r_state == RUN);
    w_hs       = in_valid && (r_state == RUN) && !start;
    w_mismatch = (dut_out != w_exp);
    w_seq_hit  = (in_vec != r_idx);
    w_err_next = r_err_count + {{N_IN{1'b0}}, (w_hs & w_mismatch)};
    w_seq_next = r_seq_err | (w_hs & w_seq_hit);
  end

  // Result registers: start clears, each accepted sample updates counts and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_err_count <= '0;
      r_ffv       <= 1'b0;
      r_ffi       <= '0;
      r_seq_err   <= 1'b0;
    end else if (start) begin
      r_idx       <= '0;
      r_err_count <= '0;
      r_ffv       <= 1'b0;
      r_ffi       <= '0;
      r_seq_err   <= 1'b0;
    end else if (w_hs) begin
      r_err_count <= w_err_next;
      r_seq_err   <= w_seq_next;
      if (w_mismatch && !r_ffv) begin
        r_ffv <= 1'b1;
        r_ffi <= in_vec;
      end
      // The index saturates on the last vector; only start or reset rewinds it.
      if (r_idx != LAST_IDX) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Registered status, looking at the next state so done/pass line up with the last count update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_busy <= (w_state_next == RUN);
      r_done <= (w_state_next == DONE);
      r_pass <= (w_state_next == DONE) && (w_err_next == '0) && !w_seq_next;
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign err_count        = r_err_count;
  assign first_fail_valid = r_ffv;
  assign first_fail_idx   = r_ffi;
  assign seq_err          = r_seq_err;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_tt_checker.sv
// Table-driven bench for tt_checker with the default buf/not expected table.
module tb_tt_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_vec;
  logic [1:0] dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic       first_fail_valid;
  logic [1:0] first_fail_idx;
  logic       seq_err;
  logic [1:0] dbg_state;

  int n_total;
  int n_pass;

  typedef struct {
    logic       start;
    logic       valid;
    logic [1:0] vec;
    logic [1:0] dout;
    logic       rdy;   // in_ready during the cycle the row is driven
    logic       busy;  // remaining fields: outputs after the clock edge
    logic       done;
    logic       pass;
    logic [2:0] err;
    logic       ffv;
    logic [1:0] ffi;
    logic       seq;
  } row_t;

  row_t tbl[$];

  tt_checker dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_vec           (in_vec),
    .dut_out          (dut_out),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .err_count        (err_count),
    .first_fail_valid (first_fail_valid),
    .first_fail_idx   (first_fail_idx),
    .seq_err          (seq_err),
    .dbg_state        (dbg_state)
  );

  // Clock/reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s row=%0d got=%0h want=%0h", name, tag, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic row_t mk(input logic st, input logic v, input logic [1:0] vec, input logic [1:0] dout,
                              input logic rdy, input logic bsy, input logic dn, input logic ps,
                              input logic [2:0] err, input logic ffv, input logic [1:0] ffi, input logic seq);
    row_t r;
    r.start = st; r.valid = v; r.vec = vec; r.dout = dout; r.rdy = rdy;
    r.busy = bsy; r.done = dn; r.pass = ps; r.err = err; r.ffv = ffv; r.ffi = ffi; r.seq = seq;
    return r;
  endfunction

  task automatic check_all_zero(input int tag);
    check("rst_busy", tag, 32'(busy), 32'd0);
    check("rst_done", tag, 32'(done), 32'd0);
    check("rst_pass", tag, 32'(pass), 32'd0);
    check("rst_err", tag, 32'(err_count), 32'd0);
    check("rst_ffv", tag, 32'(first_fail_valid), 32'd0);
    check("rst_ffi", tag, 32'(first_fail_idx), 32'd0);
    check("rst_seq", tag, 32'(seq_err), 32'd0);
    check("rst_rdy", tag, 32'(in_ready), 32'd0);
    check("rst_state", tag, 32'(dbg_state), 32'd0);
  endtask

  // Driver: present one row, check in_ready mid-cycle, then all outputs after the edge.
  task automatic apply_row(input row_t r, input int tag);
    @(negedge clk);
    start    = r.start;
    in_valid = r.valid;
    in_vec   = r.vec;
    dut_out  = r.dout;
    #1;
    check("in_ready", tag, 32'(in_ready), 32'(r.rdy));
    @(posedge clk);
    #1;
    check("busy", tag, 32'(busy), 32'(r.busy));
    check("done", tag, 32'(done), 32'(r.done));
    check("pass", tag, 32'(pass), 32'(r.pass));
    check("err_count", tag, 32'(err_count), 32'(r.err));
    check("ff_valid", tag, 32'(first_fail_valid), 32'(r.ffv));
    check("ff_idx", tag, 32'(first_fail_idx), 32'(r.ffi));
    check("seq_err", tag, 32'(seq_err), 32'(r.seq));
  endtask

  // Start (from IDLE or DONE) followed by a correct in-order sweep ending in pass.
  task automatic clean_sweep(input int tag);
    apply_row(mk(1, 0, 2'd0, 2'b00, 0, 1, 0, 0, 3'd0, 0, 2'd0, 0), tag);
    apply_row(mk(0, 1, 2'd0, 2'b01, 1, 1, 0, 0, 3'd0, 0, 2'd0, 0), tag + 1);
    apply_row(mk(0, 1, 2'd1, 2'b00, 1, 1, 0, 0, 3'd0, 0, 2'd0, 0), tag + 2);
    apply_row(mk(0, 1, 2'd2, 2'b11, 1, 1, 0, 0, 3'd0, 0, 2'd0, 0), tag + 3);
    apply_row(mk(0, 1, 2'd3, 2'b10, 1, 0, 1, 1, 3'd0, 0, 2'd0, 0), tag + 4);
  endtask

  initial begin
    n_total  = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_vec   = 2'd0;
    dut_out  = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero(0);
    @(negedge clk);
    rst_n = 1'b1;

    // Samples offered in IDLE are ignored.
    tbl.push_back(mk(0, 1, 2'd0, 2'b11, 0, 0, 0, 0, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 2'd1, 2'b11, 0, 0, 0, 0, 3'd0, 0, 2'd0, 0));
    // Clean in-order sweep.
    tbl.push_back(mk(1, 0, 2'd0, 2'b00, 0, 1, 0, 0, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 2'd0, 2'b01, 1, 1, 0, 0, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 2'd1, 2'b00, 1, 1, 0, 0, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 2'd2, 2'b11, 1, 1, 0, 0, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 2'd3, 2'b10, 1, 0, 1, 1, 3'd0, 0, 2'd0, 0));
    // Samples offered in DONE are ignored; results hold.
    tbl.push_back(mk(0, 1, 2'd0, 2'b11, 0, 0, 1, 1, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 2'd3, 2'b00, 0, 0, 1, 1, 3'd0, 0, 2'd0, 0));
    // Two mismatches at v2 and v3; first failure recorded at 2.
    tbl.push_back(mk(1, 0, 2'd0, 2'b00, 0, 1, 0, 0, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 2'd0, 2'b01, 1, 1, 0, 0, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 2'd1, 2'b00, 1, 1, 0, 0, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 2'd2, 2'b10, 1, 1, 0, 0, 3'd1, 1, 2'd2, 0));
    tbl.push_back(mk(0, 1, 2'd3, 2'b00, 1, 0, 1, 0, 3'd2, 1, 2'd2, 0));
    // Out-of-order sweep 0,2,1,3 with correct outputs.
    tbl.push_back(mk(1, 0, 2'd0, 2'b00, 0, 1, 0, 0, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 2'd0, 2'b01, 1, 1, 0, 0, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 2'd2, 2'b11, 1, 1, 0, 0, 3'd0, 0, 2'd0, 1));
    tbl.push_back(mk(0, 1, 2'd1, 2'b00, 1, 1, 0, 0, 3'd0, 0, 2'd0, 1));
    tbl.push_back(mk(0, 1, 2'd3, 2'b10, 1, 0, 1, 0, 3'd0, 0, 2'd0, 1));
    // Restart mid-sweep after a mismatch; the same-cycle sample is dropped.
    tbl.push_back(mk(1, 0, 2'd0, 2'b00, 0, 1, 0, 0, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 2'd0, 2'b01, 1, 1, 0, 0, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 0, 2'd1, 2'b11, 1, 1, 0, 0, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 2'd1, 2'b11, 1, 1, 0, 0, 3'd1, 1, 2'd1, 0));
    tbl.push_back(mk(0, 1, 2'd2, 2'b11, 1, 1, 0, 0, 3'd1, 1, 2'd1, 0));
    tbl.push_back(mk(1, 1, 2'd3, 2'b00, 1, 1, 0, 0, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 2'd0, 2'b01, 1, 1, 0, 0, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 2'd1, 2'b00, 1, 1, 0, 0, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 2'd2, 2'b11, 1, 1, 0, 0, 3'd0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 2'd3, 2'b10, 1, 0, 1, 1, 3'd0, 0, 2'd0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply_row(tbl[i], i + 1);
    end

    // Asynchronous reset mid-sweep after two handshakes (second one mismatching).
    apply_row(mk(1, 0, 2'd0, 2'b00, 0, 1, 0, 0, 3'd0, 0, 2'd0, 0), 200);
    apply_row(mk(0, 1, 2'd0, 2'b01, 1, 1, 0, 0, 3'd0, 0, 2'd0, 0), 201);
    apply_row(mk(0, 1, 2'd1, 2'b11, 1, 1, 0, 0, 3'd1, 1, 2'd1, 0), 202);
    @(negedge clk);
    in_valid = 1'b1;
    in_vec   = 2'd2;
    dut_out  = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero(203);
    @(posedge clk);
    #1;
    check_all_zero(204);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    clean_sweep(210);

    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
